// File: rtl/trigger_frame_reader.sv
// rtl/trigger_frame_reader.sv - read side of the triggered capture buffer
//
// Reads the DEPTH samples of a completed frame from a 1-cycle-latency RAM,
// converts each to a screen Y coordinate and streams them to the plotter.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   frame_valid         1-cycle pulse: complete frame in RAM
//   frame_start_addr    RAM address of the oldest sample (with frame_valid)
//   rd_en, rd_addr      RAM read strobe / address
//   rd_data             RAM data, valid the cycle after rd_en
//   out_valid/out_ready sample handshake to the plotter
//   out_x, out_y        sample index within frame / screen Y
//   out_last            marks out_x = DEPTH-1
//   busy                readout in progress (covers the done cycle)
//   done                1-cycle pulse after the last sample handshake
//   overrun             sticky: frame_valid arrived while busy
module trigger_frame_reader #(
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 12,
  parameter int OUT_W    = 8,
  parameter int Y_W      = 10,
  parameter int Y_OFFSET = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  input  logic [ADDR_W-1:0] frame_start_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_x,
  output logic [Y_W-1:0]    out_y,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam logic [Y_W-1:0]    Y_OFF     = Y_W'(Y_OFFSET);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_X    = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
  logic              inflight_q;
  logic [Y_W-1:0]    fifo_q [2];
  logic              wr_idx_q, rd_idx_q;
  logic [1:0]        count_q;
  logic [ADDR_W-1:0] x_q;
  logic              done_q, overrun_q;

  logic              pop, start, issue, last_pop;
  logic [1:0]        occupancy;
  logic [OUT_W-1:0]  scaled, scaled_inv;
  logic [Y_W-1:0]    y_new;

  // Y is computed on capture so the FIFO holds ready-to-send coordinates.
  // 2^OUT_W-1-scaled is simply the bitwise inverse of scaled.
  assign scaled     = rd_data[DATA_W-1 -: OUT_W];
  assign scaled_inv = ~scaled;
  assign y_new      = Y_OFF + {{(Y_W-OUT_W){1'b0}}, scaled_inv};

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_x     = x_q;
  assign out_y     = out_valid ? fifo_q[rd_idx_q] : '0;
  assign out_last  = out_valid & (x_q == LAST_X);
  assign last_pop  = pop & out_last;

  // done_q keeps busy high for the done cycle so a new frame there is rejected.
  assign busy    = (state_q != IDLE) | done_q;
  assign done    = done_q;
  assign overrun = overrun_q;
  assign start   = frame_valid & (state_q == IDLE) & ~done_q;
  assign rd_addr = rd_ptr_q;

  // Slots committed after this cycle: stored + arriving - leaving. A read
  // is only issued when a FIFO slot is guaranteed for its data.
  assign occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue     = (state_q == STREAM) & (issue_cnt_q != '0) & (occupancy < 2'd2);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    issue_cnt_d = issue_cnt_q;
    rd_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rd_ptr_d    = frame_start_addr;
          issue_cnt_d = DEPTH_CNT;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (issue) begin
          rd_en       = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;  // natural wrap modulo DEPTH
          issue_cnt_d = issue_cnt_q - 1'b1;
          if (issue_cnt_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      issue_cnt_q <= '0;
      inflight_q  <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_idx_q    <= 1'b0;
      rd_idx_q    <= 1'b0;
      count_q     <= 2'd0;
      x_q         <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= rd_en;
      if (inflight_q) begin
        fifo_q[wr_idx_q] <= y_new;
        wr_idx_q         <= ~wr_idx_q;
      end
      if (pop) rd_idx_q <= ~rd_idx_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
      if (start) begin
        x_q <= '0;
      end else if (pop) begin
        x_q <= x_q + 1'b1;
      end
      done_q    <= (state_q == DRAIN) & last_pop;
      overrun_q <= overrun_q | (frame_valid & busy);
    end
  end

endmodule

// File: tb/tb_trigger_frame_reader.sv
// tb/tb_trigger_frame_reader.sv - directed self-checking bench for trigger_frame_reader
module tb_trigger_frame_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_valid;
  logic [7:0] frame_start_addr;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [11:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_x;
  logic [9:0] out_y;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  int exp_start;
  int n_iss;
  int n_pop;
  bit stall_prev;

  logic [11:0] ram [256];

  always #5 clk = ~clk;

  trigger_frame_reader dut (
    .clk              (clk),
    .rst              (rst),
    .frame_valid      (frame_valid),
    .frame_start_addr (frame_start_addr),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_x            (out_x),
    .out_y            (out_y),
    .out_last         (out_last),
    .busy             (busy),
    .done             (done),
    .overrun          (overrun)
  );

  // RAM model with 1-cycle read latency
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Per-cycle scoreboard: RAM[i] = i*16, so the sample at frame index n has
  // scaled value (start+n)%256 and Y = 100 + 255 - that.
  task automatic observe();
    bit pop;
    pop = out_valid && out_ready;
    if (stall_prev) check("stall_hold_valid", out_valid, 1);
    if (rd_en) begin
      check("rd_room", int'((n_iss - n_pop - int'(pop)) < 2), 1);
      check("rd_addr", rd_addr, (exp_start + n_iss) % 256);
      n_iss++;
    end
    if (out_valid) begin
      check("out_x", out_x, n_pop);
      check("out_y", out_y, 355 - ((exp_start + n_pop) % 256));
      check("out_last", out_last, int'(n_pop == 255));
    end
    if (pop) n_pop++;
    stall_prev = out_valid && !out_ready;
  endtask

  // mode: 0 ready high, 1 random ready, 2 ready low 20 cycles after first valid
  task automatic run_frame(input int start, input int mode, input bit inject,
                           input bit do_rst, input bit fv_at_done, input int exp_ovr);
    int idx, first_v, last_pop_idx, done_idx;
    bit fin, injected;
    exp_start = start; n_iss = 0; n_pop = 0; stall_prev = 0;
    idx = 0; first_v = 0; last_pop_idx = 0; done_idx = 0; fin = 0; injected = 0;
    @(negedge clk);
    frame_valid = 1'b1;
    frame_start_addr = 8'(start);
    out_ready = (mode == 0);
    #1 check("busy_before", busy, 0);
    while (!fin && idx < 3000) begin
      @(negedge clk);
      idx++;
      frame_valid = 1'b0;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (first_v > 0) && (idx >= first_v + 20);
      endcase
      if (inject && !injected && n_pop == 100) begin
        frame_valid = 1'b1;
        frame_start_addr = 8'd3;
        injected = 1;
      end
      if (do_rst && n_pop == 50) begin
        rst = 1'b1;
        #1;
        check("rst_rd_en", rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        fin = 1;
      end else begin
        #1;
        if (idx == 1) check("busy_start", busy, 1);
        if (out_valid && first_v == 0) first_v = idx;
        if (out_valid && out_ready && n_pop == 255) last_pop_idx = idx;
        observe();
        if (mode == 2 && first_v > 0 && idx == first_v + 19) begin
          check("stall_reads", n_iss, 2);
          check("stall_x", out_x, 0);
        end
        if (done) begin
          done_idx = idx;
          fin = 1;
        end
      end
    end
    if (!fin) check("timeout", 0, 1);
    if (do_rst) begin
      repeat (2) begin
        @(negedge clk);
        #1 check("rst_no_done", done, 0);
      end
      @(negedge clk);
      rst = 1'b0;
    end else begin
      check("pop_count", n_pop, 256);
      check("read_count", n_iss, 256);
      check("busy_in_done", busy, 1);
      check("overrun", overrun, exp_ovr);
      if (mode == 0) begin
        check("first_valid_idx", first_v, 3);
        check("last_pop_idx", last_pop_idx, 258);
        check("done_idx", done_idx, 259);
      end
      if (fv_at_done) begin
        frame_valid = 1'b1;
        frame_start_addr = 8'd5;
      end
      @(negedge clk);
      frame_valid = 1'b0;
      #1;
      check("done_pulse", done, 0);
      check("busy_after", busy, 0);
      check("idle_rd_en", rd_en, 0);
      check("overrun_after", overrun, int'(exp_ovr != 0 || fv_at_done));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 12'(i * 16);
    rst = 1'b1;
    frame_valid = 1'b0;
    frame_start_addr = 8'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_rd_en", rd_en, 0);
    check("reset_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;

    run_frame(0,   0, 0, 0, 0, 0);  // full frame, no backpressure
    run_frame(250, 0, 0, 0, 0, 0);  // wrapping start address
    run_frame(37,  1, 0, 0, 0, 0);  // random backpressure
    run_frame(0,   2, 0, 0, 0, 0);  // long stall after first sample
    run_frame(0,   0, 1, 0, 0, 1);  // second frame_valid at x=100
    run_frame(200, 0, 0, 0, 0, 1);  // new frame accepted after overrun
    run_frame(90,  0, 0, 1, 0, 0);  // reset at x=50
    run_frame(17,  0, 0, 0, 1, 0);  // clean frame after reset, frame_valid in done cycle
    run_frame(128, 1, 0, 0, 0, 1);  // overrun stays sticky

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
